// File: rtl/vga_font_ram.sv
// Writable multi-bank glyph RAM with a 2-stage read port, a valid/ready write port
// and a hardware clear sequencer that zeroes the array after reset or on request.
//
// state   | meaning
// S_CLEAR | writing 0 to address r_cnt each cycle, writes refused, reads return 0
// S_READY | normal read/write operation
module vga_font_ram #(
    parameter int CHAR_BITS = 7,
    parameter int ROW_BITS  = 4,
    parameter int GLYPH_W   = 8,
    parameter int BANK_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_en_i,
    input  logic [BANK_BITS-1:0] rd_bank_i,
    input  logic [CHAR_BITS-1:0] rd_char_i,
    input  logic [ROW_BITS-1:0]  rd_row_i,
    input  logic                 rd_inv_i,
    output logic                 rd_valid_o,
    output logic [0:GLYPH_W-1]   rd_data_o,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [BANK_BITS-1:0] wr_bank_i,
    input  logic [CHAR_BITS-1:0] wr_char_i,
    input  logic [ROW_BITS-1:0]  wr_row_i,
    input  logic [0:GLYPH_W-1]   wr_data_i,
    input  logic                 clr_i,
    output logic                 busy_o
);
    localparam int AW    = BANK_BITS + CHAR_BITS + ROW_BITS;
    localparam int DEPTH = 2 ** AW;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:GLYPH_W-1] r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [AW-1:0]      r_cnt;
    logic               r_s1_valid;
    logic               r_s1_inv;
    logic [0:GLYPH_W-1] r_s1_data;
    logic               r_s2_valid;
    logic [0:GLYPH_W-1] r_s2_data;

    logic               w_busy;
    logic               w_wr_acc;
    logic               w_hit;
    logic [AW-1:0]      w_rd_addr;
    logic [AW-1:0]      w_wr_addr;

    assign w_rd_addr  = {rd_bank_i, rd_char_i, rd_row_i};
    assign w_wr_addr  = {wr_bank_i, wr_char_i, wr_row_i};
    assign w_busy     = (r_state == S_CLEAR);
    assign busy_o     = w_busy;
    assign wr_ready_o = !w_busy && !clr_i;
    assign w_wr_acc   = wr_valid_i && wr_ready_o;
    assign w_hit      = w_wr_acc && (w_wr_addr == w_rd_addr);
    assign rd_valid_o = r_s2_valid;
    assign rd_data_o  = r_s2_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1)
                        r_state <= S_READY;
                end
                S_READY: begin
                    if (clr_i) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // The clear walk owns the write port; accepted writes are impossible while busy.
    always_ff @(posedge clk_i) begin
        if (w_busy)
            r_mem[r_cnt] <= '0;
        else if (w_wr_acc)
            r_mem[w_wr_addr] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            if (w_busy)
                r_s1_data <= '0;
            else if (w_hit)
                r_s1_data <= wr_data_i;
            else
                r_s1_data <= r_mem[w_rd_addr];
            r_s1_inv <= rd_inv_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= rd_en_i;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
                r_s2_data <= r_s1_data ^ {GLYPH_W{r_s1_inv}};
        end
    end

endmodule

// File: tb/tb_vga_font_ram.sv
// Directed bench for vga_font_ram: clear timing, read latency, bypass, banks,
// inversion, clear-on-request and reset with reads in flight.
module tb_vga_font_ram;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rd_en_i;
    logic [0:0] rd_bank_i;
    logic [6:0] rd_char_i;
    logic [3:0] rd_row_i;
    logic       rd_inv_i;
    logic       rd_valid_o;
    logic [0:7] rd_data_o;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [0:0] wr_bank_i;
    logic [6:0] wr_char_i;
    logic [3:0] wr_row_i;
    logic [0:7] wr_data_i;
    logic       clr_i;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    vga_font_ram dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_en_i(rd_en_i), .rd_bank_i(rd_bank_i), .rd_char_i(rd_char_i),
        .rd_row_i(rd_row_i), .rd_inv_i(rd_inv_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_bank_i(wr_bank_i), .wr_char_i(wr_char_i), .wr_row_i(wr_row_i),
        .wr_data_i(wr_data_i), .clr_i(clr_i), .busy_o(busy_o)
    );

    always #20 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rd(input logic en, input logic [0:0] b, input logic [6:0] c,
                          input logic [3:0] r, input logic inv);
        rd_en_i = en; rd_bank_i = b; rd_char_i = c; rd_row_i = r; rd_inv_i = inv;
    endtask

    task automatic set_wr(input logic v, input logic [0:0] b, input logic [6:0] c,
                          input logic [3:0] r, input logic [7:0] d);
        wr_valid_i = v; wr_bank_i = b; wr_char_i = c; wr_row_i = r; wr_data_i = d;
    endtask

    task automatic read_chk(input string tag, input logic [0:0] b, input logic [6:0] c,
                            input logic [3:0] r, input logic inv, input logic [7:0] exp);
        set_rd(1'b1, b, c, r, inv);
        step();
        rd_en_i = 1'b0;
        step();
        chk({tag, "_valid"}, {31'd0, rd_valid_o}, 32'd1);
        chk(tag, {24'd0, rd_data_o}, {24'd0, exp});
    endtask

    task automatic write1(input logic [0:0] b, input logic [6:0] c, input logic [3:0] r,
                          input logic [7:0] d);
        set_wr(1'b1, b, c, r, d);
        step();
        wr_valid_i = 1'b0;
    endtask

    logic [7:0] glyph_a [16] = '{8'h10, 8'h28, 8'h44, 8'h82, 8'h82, 8'hFE, 8'h82, 8'h82,
                                 8'h82, 8'h82, 8'h00, 8'h00, 8'h3C, 8'h66, 8'h81, 8'hFF};

    initial begin
        int  n;
        bit  seen_rdy;
        bit  seen_vld;

        rst_i = 1'b1; clr_i = 1'b0;
        set_rd(1'b0, 1'b0, 7'd0, 4'd0, 1'b0);
        set_wr(1'b0, 1'b0, 7'd0, 4'd0, 8'h00);
        step(); step();
        chk("rst_busy", {31'd0, busy_o}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready_o}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data_o}, 32'd0);

        // Power-up clear length
        rst_i = 1'b0;
        n = 0; seen_rdy = 0;
        while (busy_o && n < 10000) begin
            if (wr_ready_o) seen_rdy = 1;
            n++;
            step();
        end
        chk("init_clear_cycles", n, 4096);
        chk("init_clear_no_ready", {31'd0, seen_rdy}, 32'd0);
        chk("ready_after_clear", {31'd0, wr_ready_o}, 32'd1);
        read_chk("rd_b1_7f_15", 1'b1, 7'h7F, 4'd15, 1'b0, 8'h00);

        // Glyph 'A' written and read back-to-back
        for (int i = 0; i < 16; i++) begin
            set_wr(1'b1, 1'b0, 7'h41, 4'(i), glyph_a[i]);
            step();
        end
        wr_valid_i = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if (k < 16) set_rd(1'b1, 1'b0, 7'h41, 4'(k), 1'b0);
            else rd_en_i = 1'b0;
            step();
            if (k == 0) chk("a_first_lat", {31'd0, rd_valid_o}, 32'd0);
            else begin
                chk($sformatf("a_valid_%0d", k - 1), {31'd0, rd_valid_o}, 32'd1);
                chk($sformatf("a_row_%0d", k - 1), {24'd0, rd_data_o}, {24'd0, glyph_a[k - 1]});
            end
        end
        step();
        chk("a_valid_drop", {31'd0, rd_valid_o}, 32'd0);
        chk("a_data_hold", {24'd0, rd_data_o}, {24'd0, glyph_a[15]});

        // Write-first bypass on same address
        set_wr(1'b1, 1'b0, 7'h20, 4'd3, 8'hA5);
        set_rd(1'b1, 1'b0, 7'h20, 4'd3, 1'b0);
        step();
        wr_valid_i = 1'b0; rd_en_i = 1'b0;
        step();
        chk("bypass_data", {24'd0, rd_data_o}, 32'hA5);
        // Different address in the same cycle sees the old value
        set_wr(1'b1, 1'b0, 7'h20, 4'd3, 8'h5A);
        set_rd(1'b1, 1'b0, 7'h20, 4'd4, 1'b0);
        step();
        wr_valid_i = 1'b0; rd_en_i = 1'b0;
        step();
        chk("nobypass_other", {24'd0, rd_data_o}, 32'h00);
        read_chk("rd_after_overwrite", 1'b0, 7'h20, 4'd3, 1'b0, 8'h5A);

        // Bank independence and inversion
        write1(1'b0, 7'h42, 4'd5, 8'hF0);
        write1(1'b1, 7'h42, 4'd5, 8'h0F);
        read_chk("bank0_b5", 1'b0, 7'h42, 4'd5, 1'b0, 8'hF0);
        read_chk("bank1_b5", 1'b1, 7'h42, 4'd5, 1'b0, 8'h0F);
        read_chk("bank0_b5_inv", 1'b0, 7'h42, 4'd5, 1'b1, 8'h0F);
        read_chk("bank1_b5_inv", 1'b1, 7'h42, 4'd5, 1'b1, 8'hF0);

        // Clear request colliding with a write
        clr_i = 1'b1;
        set_wr(1'b1, 1'b0, 7'h43, 4'd0, 8'hFF);
        #1;
        chk("clr_refuses_wr", {31'd0, wr_ready_o}, 32'd0);
        step();
        clr_i = 1'b0; wr_valid_i = 1'b0;
        n = 0; seen_rdy = 0;
        while (busy_o && n < 10000) begin
            if (wr_ready_o) seen_rdy = 1;
            if (n == 10) set_rd(1'b1, 1'b0, 7'h41, 4'd0, 1'b0);
            if (n == 11) set_rd(1'b1, 1'b0, 7'h41, 4'd0, 1'b1);
            if (n == 12) begin
                rd_en_i = 1'b0;
                chk("clr_rd_valid", {31'd0, rd_valid_o}, 32'd1);
                chk("clr_rd_zero", {24'd0, rd_data_o}, 32'h00);
            end
            if (n == 13) chk("clr_rd_inv", {24'd0, rd_data_o}, 32'hFF);
            n++;
            step();
        end
        chk("req_clear_cycles", n, 4096);
        chk("req_clear_no_ready", {31'd0, seen_rdy}, 32'd0);
        read_chk("post_clr_a0", 1'b0, 7'h41, 4'd0, 1'b0, 8'h00);
        read_chk("post_clr_b5", 1'b1, 7'h42, 4'd5, 1'b0, 8'h00);
        read_chk("refused_wr_c0", 1'b0, 7'h43, 4'd0, 1'b0, 8'h00);

        // Reset mid-clear with reads in flight
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        repeat (100) step();
        set_rd(1'b1, 1'b0, 7'h41, 4'd1, 1'b0);
        step();
        rst_i = 1'b1;
        set_rd(1'b1, 1'b0, 7'h41, 4'd2, 1'b1);
        chk("rst_inflight_pre", {31'd0, rd_valid_o}, 32'd0);
        step();
        rst_i = 1'b0; rd_en_i = 1'b0;
        n = 0; seen_vld = 0;
        while (busy_o && n < 10000) begin
            if (rd_valid_o) seen_vld = 1;
            n++;
            step();
        end
        chk("rst_clear_cycles", n, 4096);
        chk("rst_drops_reads", {31'd0, seen_vld}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
